// File: rtl/debounce_pkg.sv
// Shared defaults and helpers for the multi-channel button debouncer.
// Optional hold-pulse logic is enabled by defining DEBOUNCE_HOLD_EN.
package debounce_pkg;

  localparam int DEB_CNT_W_DEFAULT       = 16;
  localparam int DEB_SYNC_STAGES_DEFAULT = 3;
  localparam int DEB_HOLD_W_DEFAULT      = 24;

  // Number of consecutive mismatched clocks before the debounced level toggles.
  function automatic int unsigned deb_time_clks(input int unsigned cnt_w);
    return 32'd1 << cnt_w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, stability counter, rise/fall pulses and,
// when DEBOUNCE_HOLD_EN is defined, a saturating hold counter with a hold pulse.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CNT_W       = DEB_CNT_W_DEFAULT,
  parameter int SYNC_STAGES = DEB_SYNC_STAGES_DEFAULT,
  parameter int HOLD_W      = DEB_HOLD_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pb,
  output logic o_out,
  output logic o_rise,
  output logic o_fall,
  output logic o_hold
);

  if (SYNC_STAGES < 2 || CNT_W < 1 || HOLD_W < 1) begin : g_param_guard
    $error("debounce_channel: illegal parameter value");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_out;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sync;
  logic                   w_idle;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_idle = (w_sync == r_out);

  // The all-ones compare toggles before the counter could wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_out  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pb};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_idle) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_out  <= ~r_out;
        r_cnt  <= '0;
        r_rise <= ~r_out;
        r_fall <= r_out;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_out  = r_out;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

`ifdef DEBOUNCE_HOLD_EN
  localparam logic [HOLD_W-1:0] HOLD_MAX = '1;
  localparam logic [HOLD_W-1:0] HOLD_ARM = HOLD_MAX - 1'b1;

  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_hold;

  // Pulse on the edge that lands the counter on all-ones; it then saturates.
  always_ff @(posedge clk) begin
    if (rst || !r_out) begin
      r_hold_cnt <= '0;
      r_hold     <= 1'b0;
    end else begin
      if (r_hold_cnt != HOLD_MAX) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
      r_hold <= (r_hold_cnt == HOLD_ARM);
    end
  end

  assign o_hold = r_hold;
`else
  assign o_hold = 1'b0;
`endif

endmodule

// File: rtl/multi_button_debouncer.sv
// N independent debounced button channels plus a registered any-event flag.
// Define DEBOUNCE_HOLD_EN to enable the per-channel hold pulse on pb_hold.
module multi_button_debouncer
  import debounce_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = DEB_CNT_W_DEFAULT,
  parameter int SYNC_STAGES = DEB_SYNC_STAGES_DEFAULT,
  parameter int HOLD_W      = DEB_HOLD_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] pb_in,
  output logic [NUM_CH-1:0] pb_out,
  output logic [NUM_CH-1:0] pb_rise,
  output logic [NUM_CH-1:0] pb_fall,
  output logic              pb_any,
  output logic [NUM_CH-1:0] pb_hold
);

  logic [NUM_CH-1:0] w_out;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_fall;
  logic [NUM_CH-1:0] w_hold;
  logic              r_any;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES),
      .HOLD_W     (HOLD_W)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .i_pb  (pb_in[i]),
      .o_out (w_out[i]),
      .o_rise(w_rise[i]),
      .o_fall(w_fall[i]),
      .o_hold(w_hold[i])
    );
  end

  // One cycle behind the pulses so it can feed a single wake-up input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |(w_rise | w_fall);
    end
  end

  assign pb_out  = w_out;
  assign pb_rise = w_rise;
  assign pb_fall = w_fall;
  assign pb_hold = w_hold;
  assign pb_any  = r_any;

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Directed bench for multi_button_debouncer (NUM_CH=4, CNT_W=4, SYNC_STAGES=3, HOLD_W=6).
// Hold expectations follow DEBOUNCE_HOLD_EN when the bench is built with it.
module tb_multi_button_debouncer;
  import debounce_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;
  localparam int SYNC   = 3;
  localparam int HOLD_W = 6;
  localparam int LAT    = SYNC + 16;           // step on pb_in to pb_out toggle
  localparam int HOLD_T = 63;                  // pb_rise to pb_hold

`ifdef DEBOUNCE_HOLD_EN
  localparam logic HOLD_ON = 1'b1;
`else
  localparam logic HOLD_ON = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [NUM_CH-1:0] pb_in;
  logic [NUM_CH-1:0] pb_out;
  logic [NUM_CH-1:0] pb_rise;
  logic [NUM_CH-1:0] pb_fall;
  logic              pb_any;
  logic [NUM_CH-1:0] pb_hold;

  int total = 0;
  int bad   = 0;

  logic [NUM_CH-1:0] acc_pulse;
  logic [NUM_CH-1:0] acc_hold;

  multi_button_debouncer #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC),
    .HOLD_W     (HOLD_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .pb_in  (pb_in),
    .pb_out (pb_out),
    .pb_rise(pb_rise),
    .pb_fall(pb_fall),
    .pb_any (pb_any),
    .pb_hold(pb_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n active edges, landing 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Tick n cycles, collecting every rise/fall and hold pulse seen.
  task automatic watch(input int n);
    for (int k = 0; k < n; k++) begin
      tick(1);
      acc_pulse = acc_pulse | pb_rise | pb_fall;
      acc_hold  = acc_hold | pb_hold;
    end
  endtask

  initial begin
    rst   = 1'b1;
    pb_in = 4'b1111;
    acc_pulse = '0;
    acc_hold  = '0;

    // Reset with buttons held.
    tick(5);
    chk("rst_out",  pb_out,  4'b0000);
    chk("rst_rise", pb_rise, 4'b0000);
    chk("rst_fall", pb_fall, 4'b0000);
    chk("rst_any",  pb_any,  1'b0);
    chk("rst_hold", pb_hold, 4'b0000);
    rst = 1'b0;
    tick(LAT - 1);
    chk("pwr_early", pb_out, 4'b0000);
    tick(1);
    chk("pwr_out",  pb_out,  4'b1111);
    chk("pwr_rise", pb_rise, 4'b1111);
    chk("pwr_any0", pb_any,  1'b0);
    tick(1);
    chk("pwr_rise_end", pb_rise, 4'b0000);
    chk("pwr_any1", pb_any, 1'b1);
    tick(1);
    chk("pwr_any_end", pb_any, 1'b0);

    // Release ch0, then a clean press of ch0.
    pb_in = 4'b1110;
    tick(LAT);
    chk("rel0_out",  pb_out,  4'b1110);
    chk("rel0_fall", pb_fall, 4'b0001);
    chk("rel0_rise", pb_rise, 4'b0000);
    tick(5);
    pb_in = 4'b1111;
    tick(LAT - 1);
    chk("press0_early", pb_out, 4'b1110);
    tick(1);
    chk("press0_out",  pb_out,  4'b1111);
    chk("press0_rise", pb_rise, 4'b0001);
    chk("press0_fall", pb_fall, 4'b0000);
    tick(1);
    chk("press0_once", pb_rise, 4'b0000);
    chk("press0_any",  pb_any,  1'b1);

    // Release ch1, then bounce it every 5 clocks before a final press.
    pb_in = 4'b1101;
    tick(LAT);
    chk("rel1_out",  pb_out,  4'b1101);
    chk("rel1_fall", pb_fall, 4'b0010);
    tick(3);
    acc_pulse = '0;
    for (int t = 0; t < 12; t++) begin
      pb_in[1] = ~pb_in[1];
      watch(5);
    end
    chk("bounce_pulses", acc_pulse, 4'b0000);
    chk("bounce_out", pb_out, 4'b1101);
    pb_in[1] = 1'b1;
    tick(LAT - 1);
    chk("bounce_early", pb_out, 4'b1101);
    tick(1);
    chk("bounce_out1", pb_out,  4'b1111);
    chk("bounce_rise", pb_rise, 4'b0010);

    // A 15-clock dropout on ch2 is one mismatch short of a toggle.
    tick(3);
    acc_pulse = '0;
    pb_in[2] = 1'b0;
    watch(15);
    pb_in[2] = 1'b1;
    watch(25);
    chk("glitch_pulses", acc_pulse, 4'b0000);
    chk("glitch_out", pb_out, 4'b1111);

    // ch0 and ch3 release together.
    pb_in = 4'b0110;
    tick(LAT);
    chk("simul_out",  pb_out,  4'b0110);
    chk("simul_fall", pb_fall, 4'b1001);
    chk("simul_rise", pb_rise, 4'b0000);
    tick(1);
    chk("simul_any", pb_any, 1'b1);

    // Re-press both, but reset 10 clocks into the count.
    tick(3);
    pb_in = 4'b1111;
    tick(SYNC + 10);
    chk("midrst_pre", pb_out, 4'b0110);
    rst = 1'b1;
    tick(1);
    chk("midrst_out",  pb_out,  4'b0000);
    chk("midrst_rise", pb_rise, 4'b0000);
    chk("midrst_any",  pb_any,  1'b0);
    rst = 1'b0;
    tick(LAT - 1);
    chk("midrst_early", pb_out, 4'b0000);
    tick(1);
    chk("midrst_after", pb_out, 4'b1111);
    chk("midrst_rise1", pb_rise, 4'b1111);

    // Hold pulse: all channels rose together just now.
    tick(HOLD_T - 1);
    chk("hold_early", pb_hold, 4'b0000);
    tick(1);
    chk("hold_all", pb_hold, {NUM_CH{HOLD_ON}});
    tick(1);
    chk("hold_single", pb_hold, 4'b0000);
    acc_hold = '0;
    watch(70);
    chk("hold_norepeat", acc_hold, 4'b0000);

    // Release and re-press ch0: hold pulse fires again for ch0 only.
    pb_in = 4'b1110;
    tick(LAT);
    chk("hrel_out", pb_out, 4'b1110);
    tick(2);
    pb_in = 4'b1111;
    tick(LAT);
    chk("hpress_rise", pb_rise, 4'b0001);
    tick(HOLD_T - 1);
    chk("hpress_early", pb_hold, 4'b0000);
    tick(1);
    chk("hpress_hold", pb_hold, {3'b000, HOLD_ON});
    tick(1);
    chk("hpress_single", pb_hold, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
